// File: rtl/vec_stream_reader.sv
// vec_stream_reader: replays a buffered vector from the VecFIFO
// as a valid/ready beat stream, num_repeats passes per vector.
module vec_stream_reader #(
  parameter int VecElements  = 8,
  parameter int BytesPerRead = 2,
  parameter int RepWidth     = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      vec_ready,
  input  logic [RepWidth-1:0]       num_repeats,
  input  logic [BytesPerRead*8-1:0] fifo_rd_data,
  output logic                      fifo_rd_en,
  output logic                      fifo_wrap_rd,
  output logic [BytesPerRead*8-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      m_done,
  output logic                      vec_consumed,
  output logic                      busy
);

  localparam int Chunks = VecElements / BytesPerRead;
  localparam int CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam logic [CntW-1:0] LastChunk = CntW'(Chunks - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t                state;
  logic [CntW-1:0]       chunk_cnt;
  logic [RepWidth-1:0]   rep_cnt;
  logic [RepWidth-1:0]   rep_last;

  logic out_free;
  logic capture;
  logic at_last;
  logic at_final;
  logic accept;

  assign out_free = !m_valid || m_ready;
  assign accept   = m_valid && m_ready;
  assign capture  = (state == STREAM) && out_free;
  assign at_last  = (chunk_cnt == LastChunk);
  assign at_final = at_last && (rep_cnt == rep_last);

  // FIFO strobes must coincide with the capture edge, so they
  // are decoded straight from the registered state.
  assign fifo_rd_en   = capture && !at_last;
  assign fifo_wrap_rd = capture && at_last;
  assign vec_consumed = (state == DRAIN) && accept;
  assign busy         = (state != IDLE);

  // Sequencer: pass/chunk counting and the output beat register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      chunk_cnt <= '0;
      rep_cnt   <= '0;
      rep_last  <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (vec_ready) begin
            state     <= STREAM;
            chunk_cnt <= '0;
            rep_cnt   <= '0;
            rep_last  <= (num_repeats == '0)
                         ? '0
                         : num_repeats - RepWidth'(1);
          end
        end
        STREAM: begin
          if (capture) begin
            m_data  <= fifo_rd_data;
            m_valid <= 1'b1;
            m_last  <= at_last;
            m_done  <= at_final;
            if (at_last) begin
              chunk_cnt <= '0;
              rep_cnt   <= rep_cnt + RepWidth'(1);
              if (at_final) begin
                state <= DRAIN;
              end
            end else begin
              chunk_cnt <= chunk_cnt + CntW'(1);
            end
          end else if (accept) begin
            m_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (accept) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_stream_reader.sv
// tb_vec_stream_reader: directed + randomized bench with a
// FIFO model and a pass/chunk beat scoreboard.
module tb_vec_stream_reader;

  localparam int VE  = 8;
  localparam int BPR = 2;
  localparam int RW  = 8;
  localparam int CH  = VE / BPR;
  localparam int DW  = BPR * 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vec_ready = 1'b0;
  logic [RW-1:0] num_repeats = '0;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          fifo_wrap_rd;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic          m_done;
  logic          vec_consumed;
  logic          busy;

  vec_stream_reader #(
    .VecElements (VE),
    .BytesPerRead(BPR),
    .RepWidth    (RW)
  ) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .vec_ready   (vec_ready),
    .num_repeats (num_repeats),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_wrap_rd(fifo_wrap_rd),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .m_done      (m_done),
    .vec_consumed(vec_consumed),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [VE];
  int ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= 0;
    else if (fifo_wrap_rd) ptr <= 0;
    else if (fifo_rd_en) ptr <= ptr + BPR;
  end

  always_comb begin
    fifo_rd_data = '0;
    for (int i = 0; i < BPR; i++)
      fifo_rd_data[i*8 +: 8] = mem[(ptr + i) % VE];
  end

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic          dn;
  } beat_t;

  beat_t exp_q[$];

  int cmp_n = 0;
  int err_n = 0;
  int cyc = 0;
  int first_valid;
  int cons_cyc;
  int n_rd;
  int n_wrap;
  bit stalled;
  logic [DW-1:0] hd;
  logic hl;
  logic hdn;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_model(input int passes);
    beat_t b;
    exp_q.delete();
    for (int r = 0; r < passes; r++) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < BPR; k++)
          b.d[k*8 +: 8] = mem[c*BPR + k];
        b.l  = (c == CH - 1);
        b.dn = (c == CH - 1) && (r == passes - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic tick();
    beat_t b;
    #1;
    check("strobe_excl", 64'(fifo_rd_en & fifo_wrap_rd), 64'(0));
    if (stalled) begin
      check("hold_data", 64'(m_data), 64'(hd));
      check("hold_last", 64'(m_last), 64'(hl));
      check("hold_done", 64'(m_done), 64'(hdn));
    end
    if (m_valid && !m_ready)
      check("stall_strobes", 64'({fifo_rd_en, fifo_wrap_rd}), 64'(0));
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (fifo_rd_en) n_rd++;
    if (fifo_wrap_rd) n_wrap++;
    if (vec_consumed && cons_cyc < 0) cons_cyc = cyc;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'(m_valid), 64'(0));
      end else begin
        b = exp_q.pop_front();
        check("beat_data", 64'(m_data), 64'(b.d));
        check("beat_last", 64'(m_last), 64'(b.l));
        check("beat_done", 64'(m_done), 64'(b.dn));
        check("consumed_on_done", 64'(vec_consumed), 64'(b.dn));
      end
    end
    stalled = m_valid && !m_ready;
    hd  = m_data;
    hl  = m_last;
    hdn = m_done;
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, 64'(m_data), 64'(0));
    check({tag, "_valid"}, 64'(m_valid), 64'(0));
    check({tag, "_last"}, 64'(m_last), 64'(0));
    check({tag, "_done"}, 64'(m_done), 64'(0));
    check({tag, "_rd_en"}, 64'(fifo_rd_en), 64'(0));
    check({tag, "_wrap"}, 64'(fifo_wrap_rd), 64'(0));
    check({tag, "_cons"}, 64'(vec_consumed), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic run_vec(input int reps, input int ready_pct,
                         input int stall_n, input bit poke);
    int passes;
    int t0;
    passes = (reps == 0) ? 1 : reps;
    foreach (mem[i]) mem[i] = 8'($urandom);
    build_model(passes);
    first_valid = -1;
    cons_cyc = -1;
    n_rd = 0;
    n_wrap = 0;
    stalled = 0;
    check("idle_busy", 64'(busy), 64'(0));
    num_repeats = RW'(reps);
    vec_ready = 1'b1;
    m_ready = 1'b1;
    t0 = cyc;
    tick();
    vec_ready = 1'b0;
    for (int n = 0; n < 2000 && cons_cyc < 0; n++) begin
      num_repeats = RW'($urandom);
      if (stall_n >= 0)
        m_ready = !(n >= stall_n && n < stall_n + 3);
      else
        m_ready = ($urandom_range(99) < ready_pct);
      vec_ready = poke && (n == 3) && busy;
      tick();
    end
    vec_ready = 1'b0;
    m_ready = 1'b1;
    check("consumed_seen", 64'(cons_cyc >= 0), 64'(1));
    check("first_valid_lat", 64'(first_valid - t0), 64'(2));
    if (ready_pct == 100 && stall_n < 0)
      check("consumed_at", 64'(cons_cyc - t0), 64'(CH*passes + 1));
    check("beats_left", 64'(exp_q.size()), 64'(0));
    check("rd_en_cnt", 64'(n_rd), 64'(passes*(CH-1)));
    check("wrap_cnt", 64'(n_wrap), 64'(passes));
    tick();
    check("idle_after", 64'(busy), 64'(0));
  endtask

  task automatic abort_test();
    foreach (mem[i]) mem[i] = 8'($urandom);
    build_model(2);
    first_valid = -1;
    cons_cyc = -1;
    stalled = 0;
    num_repeats = RW'(2);
    vec_ready = 1'b1;
    m_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    tick();
    tick();
    #1;
    check("abort_pre_valid", 64'(m_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    stalled = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_busy", 64'(busy), 64'(0));
      check("post_rst_valid", 64'(m_valid), 64'(0));
    end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(1, 100, -1, 0);
    run_vec(3, 100, -1, 0);
    run_vec(1, 100, 2, 0);
    run_vec(0, 100, -1, 1);
    abort_test();
    run_vec(2, 100, -1, 0);
    for (int k = 0; k < 8; k++)
      run_vec($urandom_range(0, 4), $urandom_range(30, 90),
              -1, 1'($urandom_range(0, 1)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, err_n);
    $finish;
  end

endmodule
